// File: rtl/ctrl_seq.sv
// Microcode sequencer for an 8-bit bus computer. It steps through five T-states and
// decodes t_state, opcode and flags into bus control strobes. HLT freezes the sequencer.
//
// state | meaning
// T0    | fetch: PC drives the bus, MAR loads
// T1    | fetch: memory drives the bus, IR loads, PC increments
// T2    | execute step 1 (operand address, immediate, jump, out, halt)
// T3    | execute step 2 (memory read/write for LDA, ADD, SUB, STA)
// T4    | execute step 3 (ALU result written back for ADD, SUB)
module ctrl_seq #(
    parameter int          OPCODE_W  = 4,
    parameter int unsigned EARLY_END = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                flag_z_i,
    input  logic                flag_c_i,
    output logic                hlt_o,
    output logic                pc_inc_o,
    output logic                pc_en_o,
    output logic                pc_load_o,
    output logic                mar_load_o,
    output logic                mem_en_o,
    output logic                mem_load_o,
    output logic                ir_load_o,
    output logic                ir_en_o,
    output logic                a_load_o,
    output logic                a_en_o,
    output logic                b_load_o,
    output logic                alu_sub_o,
    output logic                alu_en_o,
    output logic                flags_load_o,
    output logic                out_load_o,
    output logic [2:0]          t_state_o
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } tstate_e;

    typedef enum logic [3:0] {
        OP_LDA = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_STA = 4'h3,
        OP_LDI = 4'h4,
        OP_JMP = 4'h5,
        OP_JC  = 4'h6,
        OP_JZ  = 4'h7,
        OP_NOP = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } op_e;

    typedef struct packed {
        logic hlt;
        logic pc_inc;
        logic pc_en;
        logic pc_load;
        logic mar_load;
        logic mem_en;
        logic mem_load;
        logic ir_load;
        logic ir_en;
        logic a_load;
        logic a_en;
        logic b_load;
        logic alu_sub;
        logic alu_en;
        logic flags_load;
        logic out_load;
    } ctrl_t;

    tstate_e state_q, state_d;
    logic    halted_q, halted_d;
    logic    upper_nz;
    logic [3:0] op_eff;
    tstate_e end_state;
    ctrl_t   ctrl;
    ctrl_t   ctrl_out;

    // Opcode bits above the 4-bit decode field force a NOP rather than aliasing.
    if (OPCODE_W > 4) begin : g_upper
        assign upper_nz = |opcode_i[OPCODE_W-1:4];
    end else begin : g_no_upper
        assign upper_nz = 1'b0;
    end

    assign op_eff = upper_nz ? OP_NOP : opcode_i[3:0];

    always_comb begin
        end_state = T2;
        case (op_eff)
            OP_LDA, OP_STA: end_state = T3;
            OP_ADD, OP_SUB: end_state = T4;
            default:        end_state = T2;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= T0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        ctrl     = '0;
        if (halted_q) begin
            ctrl.hlt = 1'b1;
        end else begin
            case (state_q)
                T0: begin
                    ctrl.pc_en    = 1'b1;
                    ctrl.mar_load = 1'b1;
                end
                T1: begin
                    ctrl.mem_en  = 1'b1;
                    ctrl.ir_load = 1'b1;
                    ctrl.pc_inc  = 1'b1;
                end
                T2: begin
                    case (op_eff)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ctrl.ir_en    = 1'b1;
                            ctrl.mar_load = 1'b1;
                        end
                        OP_LDI: begin
                            ctrl.ir_en  = 1'b1;
                            ctrl.a_load = 1'b1;
                        end
                        OP_JMP: begin
                            ctrl.ir_en   = 1'b1;
                            ctrl.pc_load = 1'b1;
                        end
                        OP_JC: begin
                            ctrl.ir_en   = flag_c_i;
                            ctrl.pc_load = flag_c_i;
                        end
                        OP_JZ: begin
                            ctrl.ir_en   = flag_z_i;
                            ctrl.pc_load = flag_z_i;
                        end
                        OP_OUT: begin
                            ctrl.a_en     = 1'b1;
                            ctrl.out_load = 1'b1;
                        end
                        OP_HLT: begin
                            ctrl.hlt = 1'b1;
                            halted_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    case (op_eff)
                        OP_LDA: begin
                            ctrl.mem_en = 1'b1;
                            ctrl.a_load = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ctrl.mem_en = 1'b1;
                            ctrl.b_load = 1'b1;
                        end
                        OP_STA: begin
                            ctrl.a_en     = 1'b1;
                            ctrl.mem_load = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (op_eff == OP_ADD || op_eff == OP_SUB) begin
                        ctrl.alu_en     = 1'b1;
                        ctrl.a_load     = 1'b1;
                        ctrl.flags_load = 1'b1;
                        ctrl.alu_sub    = (op_eff == OP_SUB);
                    end
                end
                default: ;
            endcase

            // Halting holds T2; otherwise wrap at T4 or, in variable-length mode, at the last step.
            if (halted_d) begin
                state_d = state_q;
            end else if (state_q == T4 || (EARLY_END != 0 && state_q == end_state)) begin
                state_d = T0;
            end else if (state_q > T4) begin
                state_d = T0;
            end else begin
                state_d = tstate_e'(state_q + 3'd1);
            end
        end
    end

    assign ctrl_out = rst_i ? '0 : ctrl;

    assign hlt_o        = ctrl_out.hlt;
    assign pc_inc_o     = ctrl_out.pc_inc;
    assign pc_en_o      = ctrl_out.pc_en;
    assign pc_load_o    = ctrl_out.pc_load;
    assign mar_load_o   = ctrl_out.mar_load;
    assign mem_en_o     = ctrl_out.mem_en;
    assign mem_load_o   = ctrl_out.mem_load;
    assign ir_load_o    = ctrl_out.ir_load;
    assign ir_en_o      = ctrl_out.ir_en;
    assign a_load_o     = ctrl_out.a_load;
    assign a_en_o       = ctrl_out.a_en;
    assign b_load_o     = ctrl_out.b_load;
    assign alu_sub_o    = ctrl_out.alu_sub;
    assign alu_en_o     = ctrl_out.alu_en;
    assign flags_load_o = ctrl_out.flags_load;
    assign out_load_o   = ctrl_out.out_load;
    assign t_state_o    = rst_i ? 3'd0 : state_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: a variable-length instance (OPCODE_W=5) and a fixed-length instance
// (OPCODE_W=4), each compared cycle by cycle with a per-instruction micro-step list.
module tb_ctrl_seq;

    localparam logic [15:0] M_HLT   = 16'h8000;
    localparam logic [15:0] M_PCINC = 16'h4000;
    localparam logic [15:0] M_PCEN  = 16'h2000;
    localparam logic [15:0] M_PCLD  = 16'h1000;
    localparam logic [15:0] M_MAR   = 16'h0800;
    localparam logic [15:0] M_MEMEN = 16'h0400;
    localparam logic [15:0] M_MEMLD = 16'h0200;
    localparam logic [15:0] M_IRLD  = 16'h0100;
    localparam logic [15:0] M_IREN  = 16'h0080;
    localparam logic [15:0] M_ALD   = 16'h0040;
    localparam logic [15:0] M_AEN   = 16'h0020;
    localparam logic [15:0] M_BLD   = 16'h0010;
    localparam logic [15:0] M_SUB   = 16'h0008;
    localparam logic [15:0] M_ALUEN = 16'h0004;
    localparam logic [15:0] M_FLG   = 16'h0002;
    localparam logic [15:0] M_OUT   = 16'h0001;
    localparam logic [15:0] M_BUS   = M_PCEN | M_MEMEN | M_IREN | M_AEN | M_ALUEN;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // instance E: EARLY_END=1, OPCODE_W=5
    logic       rst_e = 1'b1;
    logic [4:0] op_e  = '0;
    logic       fz_e  = 1'b0;
    logic       fc_e  = 1'b0;
    logic [15:0] ctrl_e;
    logic [2:0]  t_e;
    // instance F: EARLY_END=0, OPCODE_W=4
    logic       rst_f = 1'b1;
    logic [3:0] op_f  = '0;
    logic       fz_f  = 1'b0;
    logic       fc_f  = 1'b0;
    logic [15:0] ctrl_f;
    logic [2:0]  t_f;

    ctrl_seq #(.OPCODE_W(5), .EARLY_END(1)) u_dut_e (
        .clk_i(clk), .rst_i(rst_e), .opcode_i(op_e), .flag_z_i(fz_e), .flag_c_i(fc_e),
        .hlt_o(ctrl_e[15]), .pc_inc_o(ctrl_e[14]), .pc_en_o(ctrl_e[13]), .pc_load_o(ctrl_e[12]),
        .mar_load_o(ctrl_e[11]), .mem_en_o(ctrl_e[10]), .mem_load_o(ctrl_e[9]), .ir_load_o(ctrl_e[8]),
        .ir_en_o(ctrl_e[7]), .a_load_o(ctrl_e[6]), .a_en_o(ctrl_e[5]), .b_load_o(ctrl_e[4]),
        .alu_sub_o(ctrl_e[3]), .alu_en_o(ctrl_e[2]), .flags_load_o(ctrl_e[1]), .out_load_o(ctrl_e[0]),
        .t_state_o(t_e)
    );

    ctrl_seq #(.OPCODE_W(4), .EARLY_END(0)) u_dut_f (
        .clk_i(clk), .rst_i(rst_f), .opcode_i(op_f), .flag_z_i(fz_f), .flag_c_i(fc_f),
        .hlt_o(ctrl_f[15]), .pc_inc_o(ctrl_f[14]), .pc_en_o(ctrl_f[13]), .pc_load_o(ctrl_f[12]),
        .mar_load_o(ctrl_f[11]), .mem_en_o(ctrl_f[10]), .mem_load_o(ctrl_f[9]), .ir_load_o(ctrl_f[8]),
        .ir_en_o(ctrl_f[7]), .a_load_o(ctrl_f[6]), .a_en_o(ctrl_f[5]), .b_load_o(ctrl_f[4]),
        .alu_sub_o(ctrl_f[3]), .alu_en_o(ctrl_f[2]), .flags_load_o(ctrl_f[1]), .out_load_o(ctrl_f[0]),
        .t_state_o(t_f)
    );

    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: list of control words, one per clock, for one whole instruction.
    function automatic void build_steps(input logic [4:0] op, input logic fz, input logic fc,
                                        input bit early);
        exp_q.delete();
        exp_q.push_back(M_PCEN | M_MAR);
        exp_q.push_back(M_MEMEN | M_IRLD | M_PCINC);
        if (op > 5'd15) exp_q.push_back(16'h0);
        else case (op[3:0])
            4'h0: begin exp_q.push_back(M_IREN | M_MAR); exp_q.push_back(M_MEMEN | M_ALD); end
            4'h1: begin
                exp_q.push_back(M_IREN | M_MAR); exp_q.push_back(M_MEMEN | M_BLD);
                exp_q.push_back(M_ALUEN | M_ALD | M_FLG);
            end
            4'h2: begin
                exp_q.push_back(M_IREN | M_MAR); exp_q.push_back(M_MEMEN | M_BLD);
                exp_q.push_back(M_ALUEN | M_ALD | M_FLG | M_SUB);
            end
            4'h3: begin exp_q.push_back(M_IREN | M_MAR); exp_q.push_back(M_AEN | M_MEMLD); end
            4'h4: exp_q.push_back(M_IREN | M_ALD);
            4'h5: exp_q.push_back(M_IREN | M_PCLD);
            4'h6: exp_q.push_back(fc ? (M_IREN | M_PCLD) : 16'h0);
            4'h7: exp_q.push_back(fz ? (M_IREN | M_PCLD) : 16'h0);
            4'hE: exp_q.push_back(M_AEN | M_OUT);
            default: exp_q.push_back(16'h0);
        endcase
        if (!early) while (exp_q.size() < 5) exp_q.push_back(16'h0);
    endfunction

    function automatic logic [15:0] ctrl_of(input bit sel);
        return sel ? ctrl_f : ctrl_e;
    endfunction

    function automatic logic [2:0] t_of(input bit sel);
        return sel ? t_f : t_e;
    endfunction

    // Called at negedge+1 with the DUT in T0; returns at negedge+1 of the next T0.
    task automatic run_instr(input bit sel, input logic [4:0] op, input logic fz, input logic fc);
        logic [15:0] c;
        if (sel) begin op_f = op[3:0]; fz_f = fz; fc_f = fc; end
        else     begin op_e = op;      fz_e = fz; fc_e = fc; end
        build_steps(op, fz, fc, !sel);
        foreach (exp_q[i]) begin
            c = ctrl_of(sel);
            check($sformatf("dut%0d op%0h t%0d state", sel, op, i), 32'(t_of(sel)), i);
            check($sformatf("dut%0d op%0h t%0d ctrl", sel, op, i), 32'(c), 32'(exp_q[i]));
            check($sformatf("dut%0d op%0h t%0d bus", sel, op, i),
                  32'($countones(c & M_BUS) <= 1), 32'd1);
            @(negedge clk); #1;
        end
    endtask

    task automatic run_halt(input bit sel, input int hold_cycles);
        if (sel) op_f = 4'hF; else op_e = 5'h0F;
        check($sformatf("dut%0d hlt t0", sel), 32'(ctrl_of(sel)), 32'(M_PCEN | M_MAR));
        @(negedge clk); #1;
        check($sformatf("dut%0d hlt t1", sel), 32'(ctrl_of(sel)), 32'(M_MEMEN | M_IRLD | M_PCINC));
        @(negedge clk); #1;
        check($sformatf("dut%0d hlt t2 state", sel), 32'(t_of(sel)), 32'd2);
        check($sformatf("dut%0d hlt t2 ctrl", sel), 32'(ctrl_of(sel)), 32'(M_HLT));
        for (int k = 0; k < hold_cycles; k++) begin
            @(negedge clk); #1;
            if (sel) begin op_f = 4'($urandom); fz_f = 1'($urandom); fc_f = 1'($urandom); end
            else     begin op_e = 5'($urandom); fz_e = 1'($urandom); fc_e = 1'($urandom); end
            #1;
            check($sformatf("dut%0d halted state %0d", sel, k), 32'(t_of(sel)), 32'd2);
            check($sformatf("dut%0d halted ctrl %0d", sel, k), 32'(ctrl_of(sel)), 32'(M_HLT));
        end
        if (sel) rst_f = 1'b1; else rst_e = 1'b1;
        #1;
        check($sformatf("dut%0d rst comb ctrl", sel), 32'(ctrl_of(sel)), 32'd0);
        @(negedge clk); #1;
        check($sformatf("dut%0d rst state", sel), 32'(t_of(sel)), 32'd0);
        check($sformatf("dut%0d rst ctrl", sel), 32'(ctrl_of(sel)), 32'd0);
        if (sel) rst_f = 1'b0; else rst_e = 1'b0;
        #1;
        check($sformatf("dut%0d post rst t0", sel), 32'(ctrl_of(sel)), 32'(M_PCEN | M_MAR));
    endtask

    logic [4:0] rop;

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("reset e state", 32'(t_e), 32'd0);
        check("reset e ctrl", 32'(ctrl_e), 32'd0);
        check("reset f state", 32'(t_f), 32'd0);
        check("reset f ctrl", 32'(ctrl_f), 32'd0);

        rst_e = 1'b0;
        #1;
        check("first t0 e", 32'(ctrl_e), 32'(M_PCEN | M_MAR));
        run_instr(0, 5'h04, 1'b0, 1'b0);
        run_instr(0, 5'h01, 1'b1, 1'b1);
        run_instr(0, 5'h02, 1'b0, 1'b0);
        run_instr(0, 5'h07, 1'b0, 1'b1);
        run_instr(0, 5'h07, 1'b1, 1'b0);
        run_instr(0, 5'h06, 1'b1, 1'b0);
        run_instr(0, 5'h06, 1'b0, 1'b1);
        run_instr(0, 5'h00, 1'b0, 1'b0);
        run_instr(0, 5'h03, 1'b0, 1'b0);
        run_instr(0, 5'h05, 1'b0, 1'b0);
        run_instr(0, 5'h0E, 1'b0, 1'b0);
        run_instr(0, 5'h1F, 1'b0, 1'b0);
        run_instr(0, 5'h14, 1'b0, 1'b0);
        run_instr(0, 5'h11, 1'b0, 1'b0);
        for (int n = 8; n <= 13; n++) run_instr(0, 5'(n), 1'b1, 1'b1);
        for (int n = 0; n < 40; n++) begin
            rop = 5'($urandom_range(0, 31));
            if (rop == 5'h0F) rop = 5'h1F;
            run_instr(0, rop, 1'($urandom), 1'($urandom));
        end
        run_halt(0, 12);
        run_instr(0, 5'h04, 1'b0, 1'b0);
        check("e final t0", 32'(t_e), 32'd0);
        rst_e = 1'b1;

        rst_f = 1'b0;
        #1;
        check("first t0 f", 32'(ctrl_f), 32'(M_PCEN | M_MAR));
        run_instr(1, 5'h00, 1'b0, 1'b0);
        run_instr(1, 5'h04, 1'b0, 1'b0);
        run_instr(1, 5'h02, 1'b0, 1'b0);
        run_instr(1, 5'h07, 1'b1, 1'b0);
        run_instr(1, 5'h06, 1'b0, 1'b0);
        for (int n = 0; n < 30; n++)
            run_instr(1, 5'($urandom_range(0, 14)), 1'($urandom), 1'($urandom));

        // reset in the middle of an ADD
        op_f = 4'h1;
        repeat (3) @(negedge clk);
        #1;
        check("f mid state", 32'(t_f), 32'd3);
        rst_f = 1'b1;
        @(negedge clk); #1;
        check("f mid rst state", 32'(t_f), 32'd0);
        check("f mid rst ctrl", 32'(ctrl_f), 32'd0);
        rst_f = 1'b0;
        #1;
        run_instr(1, 5'h01, 1'b0, 1'b0);
        run_halt(1, 10);
        run_instr(1, 5'h0E, 1'b0, 1'b0);
        check("f final t0", 32'(t_f), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ctrl_seq.md
CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 Parameter OPCODE_W, default 4, opcode input width; must be at least 4.
REQ-002 Parameter EARLY_END, default 1; 1 = variable-length instructions, 0 = every instruction occupies all five T-states.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 opcode  input  OPCODE_W  instruction register opcode field.
REQ-006 flag_z, flag_c  input  1 each  zero and carry flags from the flags register.
REQ-007 hlt  output  1  halt request to the clock block.
REQ-008 pc_inc, pc_en, pc_load  output  1 each  PC increment, PC drive bus, PC load from bus.
REQ-009 mar_load, mem_en, mem_load  output  1 each  MAR load, memory drive bus, memory write from bus.
REQ-010 ir_load, ir_en  output  1 each  IR load, IR operand drive bus.
REQ-011 a_load, a_en, b_load  output  1 each  A load, A drive bus, B load.
REQ-012 alu_sub, alu_en, flags_load, out_load  output  1 each  subtract select, ALU drive bus, flags capture, output register load.
REQ-013 t_state  output  3  current T-state index, 0..4.

Function
REQ-014 The T-state counter shall advance T0->T1->T2->T3->T4->T0, one state per clk.
REQ-015 Control outputs shall be combinational in t_state, opcode and flags; the bus-enable outputs (pc_en, mem_en, ir_en, a_en, alu_en) shall be at most one-hot in every state.
REQ-016 T0 shall assert pc_en and mar_load.
REQ-017 T1 shall assert mem_en, ir_load and pc_inc.
REQ-018 Opcode decode shall use opcode[3:0]; any nonzero opcode bit above bit 3 shall decode as NOP.
REQ-019 LDA 0x0: T2 ir_en+mar_load; T3 mem_en+a_load; instruction ends after T3.
REQ-020 ADD 0x1: T2 ir_en+mar_load; T3 mem_en+b_load; T4 alu_en+a_load+flags_load; instruction ends after T4.
REQ-021 SUB 0x2: as ADD, with alu_sub also asserted in T4.
REQ-022 STA 0x3: T2 ir_en+mar_load; T3 a_en+mem_load; instruction ends after T3.
REQ-023 LDI 0x4: T2 ir_en+a_load; instruction ends after T2.
REQ-024 JMP 0x5: T2 ir_en+pc_load; instruction ends after T2.
REQ-025 JC 0x6 and JZ 0x7: T2 ir_en+pc_load only if flag_c (JC) or flag_z (JZ) is 1, otherwise no outputs; the flag is sampled in T2; instruction ends after T2.
REQ-026 OUT 0xE: T2 a_en+out_load; instruction ends after T2.
REQ-027 HLT 0xF: in T2, hlt shall assert and an internal halted latch shall set on that edge.
REQ-028 All other opcodes (0x8-0xD) are NOP: no outputs in T2-T4; instruction ends after T2.
REQ-029 With EARLY_END=1, the counter shall return to T0 on the clk after the ending state.
REQ-030 With EARLY_END=0, the counter shall always run through T4, and states past the ending state shall assert no outputs.
REQ-031 While halted, t_state shall hold, hlt shall be 1, and all other outputs shall be 0, until rst.
REQ-032 Opcode changes during T2-T4 shall be used as-is; the block does not latch opcode.

Reset
REQ-033 While rst is 1, t_state shall be 0, halted shall be cleared, and all control outputs, including hlt, shall be 0.
REQ-034 On the first clk edge with rst 0, the block shall be in T0 and assert pc_en+mar_load.
REQ-035 rst asserted mid-instruction or while halted shall take effect on the next clk edge, regardless of T-state.

Verification
REQ-036 LDI (0x4), EARLY_END=1: t_state 0,1,2,0; a_load+ir_en in T2 only; 3 clocks per instruction.
REQ-037 ADD (0x1), EARLY_END=1: 5 clocks; T4 asserts alu_en+a_load+flags_load with alu_sub=0. SUB (0x2) asserts the same with alu_sub=1.
REQ-038 JZ (0x7) with flag_z=0: no pc_load in T2. JZ with flag_z=1: ir_en+pc_load in T2. JC (0x6) checked with flag_c in both states.
REQ-039 LDA (0x0), EARLY_END=0: t_state runs 0-4; T4 shows all outputs 0; next T0 follows.
REQ-040 HLT (0xF): hlt=1 from T2 onward; t_state frozen at 2 for 10+ clocks; rst then returns t_state 0 with hlt=0.
REQ-041 Every cycle: bus-enable outputs checked one-hot-or-zero; opcode 0x1F with OPCODE_W=5 checked to behave as NOP.
